// File: rtl/chocorrol_secuenciador.sv
// Instruction sequencer for CHOCORROL: host-loaded program RAM, PC walk, settle wait,
// and SAL capture into RESULT with a one-cycle valid strobe.
module chocorrol_secuenciador #(
    parameter int IW            = 20,
    parameter int DW            = 32,
    parameter int AW            = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          PROG_WE,
    input  logic [AW-1:0] PROG_ADDR,
    input  logic [IW-1:0] PROG_DATA,
    input  logic          START,
    input  logic [DW-1:0] SAL,
    output logic [IW-1:0] INSTRUCCION,
    output logic [DW-1:0] RESULT,
    output logic          RESULT_VALID,
    output logic [AW-1:0] PC,
    output logic          BUSY,
    output logic          DONE
);

    localparam int            CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [AW-1:0] LAST_PC     = '1;
    localparam logic [1:0]    OP_HALT     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT,
        ST_HALT,
        ST_FIN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] prog_ram [2**AW];
    logic [IW-1:0] rd_word;

    // Program RAM has no reset; host writes land only while the sequencer is idle.
    always_ff @(posedge CLK) begin
        if (RST_N && PROG_WE && state == ST_IDLE) begin
            prog_ram[PROG_ADDR] <= PROG_DATA;
        end
        if (state == ST_FETCH) begin
            rd_word <= prog_ram[PC];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            PC           <= '0;
            INSTRUCCION  <= '0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            cnt          <= '0;
        end else begin
            RESULT_VALID <= 1'b0;
            DONE         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        PC    <= '0;
                        BUSY  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    // HALT words are swallowed here so CHOCORROL never sees them.
                    if (rd_word[IW-1 -: 2] == OP_HALT) begin
                        state <= ST_HALT;
                    end else begin
                        INSTRUCCION <= rd_word;
                        cnt         <= SETTLE_LOAD;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        RESULT       <= SAL;
                        RESULT_VALID <= 1'b1;
                        // End of RAM finishes the run instead of wrapping back to 0.
                        if (PC == LAST_PC) begin
                            DONE  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            PC    <= PC + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    DONE  <= 1'b1;
                    state <= ST_FIN;
                end
                ST_FIN: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
